// File: rtl/mac_seq_ctrl.sv
// Sequencer for a row of ROWS multiply-accumulate lanes: clears the lanes, streams COLS
// column/element beats into them, waits one cycle for the last product, then holds the result.
module mac_seq_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ROWS       = 8,
    parameter int unsigned COLS       = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic                           abort_i,
    input  logic                           a_valid_i,
    output logic                           a_ready_o,
    input  logic [ROWS*DATA_WIDTH-1:0]     a_data_i,
    input  logic                           b_valid_i,
    output logic                           b_ready_o,
    input  logic [DATA_WIDTH-1:0]          b_data_i,
    output logic                           mac_en_o,
    output logic                           mac_clr_o,
    output logic [ROWS*DATA_WIDTH-1:0]     mac_a_o,
    output logic [DATA_WIDTH-1:0]          mac_b_o,
    input  logic [ROWS*3*DATA_WIDTH-1:0]   mac_cout_i,
    output logic                           res_valid_o,
    input  logic                           res_ready_i,
    output logic [ROWS*3*DATA_WIDTH-1:0]   res_data_o,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int unsigned KW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [KW-1:0] KLast = KW'(COLS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StCompute,
        StDrain,
        StResult
    } state_e;

    state_e                         state_q, state_d;
    logic [KW-1:0]                  k_q, k_d;
    logic [ROWS*3*DATA_WIDTH-1:0]   res_data_q, res_data_d;
    logic                           fire;
    logic                           mac_en, mac_clr, res_valid, done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            k_q        <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            res_data_q <= res_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        res_data_d = res_data_q;
        fire       = 1'b0;
        mac_en     = 1'b0;
        mac_clr    = 1'b0;
        res_valid  = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                mac_clr = 1'b1;
                k_d     = '0;
                state_d = StCompute;
            end
            StCompute: begin
                fire   = a_valid_i && b_valid_i;
                mac_en = fire;
                if (fire) begin
                    if (k_q == KLast) begin
                        k_d     = '0;
                        state_d = StDrain;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            StDrain: begin
                // Last beat is registered inside the lanes by now.
                res_data_d = mac_cout_i;
                state_d    = StResult;
            end
            StResult: begin
                res_valid = 1'b1;
                if (res_ready_i) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Cancel wins over beats and result acceptance; lanes are wiped on the way out.
        if (abort_i && (state_q != StIdle)) begin
            state_d    = StIdle;
            k_d        = '0;
            res_data_d = res_data_q;
            fire       = 1'b0;
            mac_en     = 1'b0;
            mac_clr    = 1'b1;
            res_valid  = 1'b0;
            done       = 1'b0;
        end
    end

    assign a_ready_o   = fire;
    assign b_ready_o   = fire;
    assign mac_en_o    = mac_en;
    assign mac_clr_o   = mac_clr;
    assign mac_a_o     = fire ? a_data_i : '0;
    assign mac_b_o     = fire ? b_data_i : '0;
    assign res_valid_o = res_valid;
    assign res_data_o  = res_data_q;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = done;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomised scoreboard bench for mac_seq_ctrl with behavioural MAC lanes attached,
// plus a second COLS=1 instance for the single-beat case.
module tb_mac_seq_ctrl;

    localparam int DW    = 8;
    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int AW    = ROWS * DW;
    localparam int LW    = 3 * DW;
    localparam int RW    = ROWS * LW;
    localparam int CW    = 512;
    localparam int ROWS1 = 2;
    localparam int LAT_MAX = 400;

    logic clk, rst_n;
    logic start, abort, a_valid, a_ready, b_valid, b_ready;
    logic [AW-1:0] a_data, mac_a;
    logic [DW-1:0] b_data, mac_b;
    logic mac_en, mac_clr, res_valid, res_ready, busy, done;
    logic [RW-1:0] mac_cout, res_data;

    logic start1, abort1, a_valid1, a_ready1, b_valid1, b_ready1;
    logic [ROWS1*DW-1:0] a_data1, mac_a1;
    logic [DW-1:0] b_data1, mac_b1;
    logic mac_en1, mac_clr1, res_valid1, res_ready1, busy1, done1;
    logic [ROWS1*LW-1:0] mac_cout1, res_data1;

    int tests_run = 0;
    int tests_failed = 0;
    int rr_mode = 0;
    logic [RW-1:0] exp_q[$];
    logic [AW-1:0] job_a[COLS];
    logic [DW-1:0] job_b[COLS];
    logic [LW-1:0] acc0[ROWS];
    logic [LW-1:0] acc1[ROWS1];

    mac_seq_ctrl #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .a_valid_i(a_valid), .a_ready_o(a_ready), .a_data_i(a_data),
        .b_valid_i(b_valid), .b_ready_o(b_ready), .b_data_i(b_data),
        .mac_en_o(mac_en), .mac_clr_o(mac_clr), .mac_a_o(mac_a), .mac_b_o(mac_b),
        .mac_cout_i(mac_cout), .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_data_o(res_data), .busy_o(busy), .done_o(done)
    );

    mac_seq_ctrl #(.DATA_WIDTH(DW), .ROWS(ROWS1), .COLS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .abort_i(abort1),
        .a_valid_i(a_valid1), .a_ready_o(a_ready1), .a_data_i(a_data1),
        .b_valid_i(b_valid1), .b_ready_o(b_ready1), .b_data_i(b_data1),
        .mac_en_o(mac_en1), .mac_clr_o(mac_clr1), .mac_a_o(mac_a1), .mac_b_o(mac_b1),
        .mac_cout_i(mac_cout1), .res_valid_o(res_valid1), .res_ready_i(res_ready1),
        .res_data_o(res_data1), .busy_o(busy1), .done_o(done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered MAC lanes: Clr beats En, products wrap at 3*DW bits.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) acc0[r] <= '0;
            for (int r = 0; r < ROWS1; r++) acc1[r] <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                if (mac_clr) acc0[r] <= '0;
                else if (mac_en) acc0[r] <= acc0[r] + LW'(mac_a[r*DW +: DW]) * LW'(mac_b);
            end
            for (int r = 0; r < ROWS1; r++) begin
                if (mac_clr1) acc1[r] <= '0;
                else if (mac_en1) acc1[r] <= acc1[r] + LW'(mac_a1[r*DW +: DW]) * LW'(mac_b1);
            end
        end
    end

    always_comb begin
        mac_cout  = '0;
        mac_cout1 = '0;
        for (int r = 0; r < ROWS; r++) mac_cout[r*LW +: LW] = acc0[r];
        for (int r = 0; r < ROWS1; r++) mac_cout1[r*LW +: LW] = acc1[r];
    end

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Dot product of each lane's column entries with the vector, truncated to 3*DW bits.
    function automatic logic [RW-1:0] model();
        logic [RW-1:0] r_v;
        r_v = '0;
        for (int r = 0; r < ROWS; r++) begin
            longint s;
            s = 0;
            for (int j = 0; j < COLS; j++)
                s += longint'(job_a[j][r*DW +: DW]) * longint'(job_b[j]);
            r_v[r*LW +: LW] = LW'(s);
        end
        return r_v;
    endfunction

    function automatic logic [RW-1:0] all_lanes(input int v);
        logic [RW-1:0] r_v;
        r_v = '0;
        for (int r = 0; r < ROWS; r++) r_v[r*LW +: LW] = LW'(v);
        return r_v;
    endfunction

    function automatic logic [CW-1:0] outs0();
        return CW'({a_ready, b_ready, mac_en, mac_clr, res_valid, busy, done,
                    res_data, mac_a, mac_b});
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'($urandom_range(1));
                default: res_ready = 1'b0;
            endcase
        end
    end

    // Monitor: protocol checks every cycle, scoreboard pop on each accepted result.
    int beats = 0;
    logic held_v = 1'b0;
    logic [RW-1:0] held_d;
    logic [RW-1:0] exp_r;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats  = 0;
            held_v = 1'b0;
        end else begin
            check("ready_vs_en", CW'({a_ready, b_ready}), CW'({mac_en, mac_en}));
            if (mac_en) begin
                check("beat_operands", CW'({a_valid, b_valid, mac_a, mac_b}),
                      CW'({2'b11, a_data, b_data}));
                beats++;
            end else begin
                check("idle_operands_zero", CW'({mac_a, mac_b}), CW'(0));
            end
            if (mac_clr) beats = 0;
            if (held_v && res_valid) check("res_hold", CW'(res_data), CW'(held_d));
            held_v = res_valid && !res_ready;
            held_d = res_data;
            if (res_valid && res_ready) begin
                check("done_on_accept", CW'(done), CW'(1));
                check("beat_count", CW'(beats), CW'(COLS));
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_result: got %0h expected none", res_data);
                end else begin
                    exp_r = exp_q.pop_front();
                    check("result", CW'(res_data), CW'(exp_r));
                end
            end else begin
                check("no_spurious_done", CW'(done), CW'(0));
            end
        end
    end

    // opmode: 0 random, 1 column j = j+1 / b = 2, 2 all 0xFF.
    // vmode: 0 always valid, 1 a_valid toggles, 2 random valids.
    // cut_beat >= 0 cancels the job once that many beats fired (abort, or reset if cut_rst).
    task automatic run_job(input int opmode, input int vmode, input int cut_beat,
                           input bit cut_rst, output int lat, output logic [RW-1:0] first_res);
        int idx;
        bit fired, seen;
        for (int j = 0; j < COLS; j++) begin
            case (opmode)
                1: begin job_a[j] = {ROWS{DW'(j + 1)}}; job_b[j] = DW'(2); end
                2: begin job_a[j] = {ROWS{8'hFF}}; job_b[j] = 8'hFF; end
                default: begin
                    for (int r = 0; r < ROWS; r++) job_a[j][r*DW +: DW] = DW'($urandom);
                    job_b[j] = DW'($urandom);
                end
            endcase
        end
        if (cut_beat < 0) exp_q.push_back(model());
        first_res = '0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        idx = 0;
        seen = 1'b0;
        while (!seen && lat < LAT_MAX) begin
            if (idx < COLS) begin
                a_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (lat % 2 == 0)
                                                             : ($urandom_range(3) != 0);
                b_valid = (vmode == 2) ? ($urandom_range(3) != 0) : 1'b1;
                a_data  = job_a[idx];
                b_data  = job_b[idx];
            end else begin
                a_valid = 1'b0;
                b_valid = 1'b0;
            end
            if (cut_beat >= 0 && idx == cut_beat) begin
                if (cut_rst) begin
                    @(negedge clk);
                    #2;
                    rst_n = 1'b0;
                    #1;
                    check("reset_mid_job_outputs", outs0(), CW'(0));
                    @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                end else begin
                    abort = 1'b1;
                    @(negedge clk);
                    check("abort_clr", CW'(mac_clr), CW'(1));
                    check("abort_quiet", CW'({mac_en, a_ready, res_valid, done}), CW'(0));
                    @(posedge clk);
                    #1;
                    abort = 1'b0;
                    check("abort_to_idle", CW'(busy), CW'(0));
                end
                a_valid = 1'b0;
                b_valid = 1'b0;
                return;
            end
            @(negedge clk);
            fired = a_ready;
            @(posedge clk);
            #1;
            lat++;
            if (fired) idx++;
            if (res_valid) begin
                seen = 1'b1;
                first_res = res_data;
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (!seen) check("result_timeout", CW'(0), CW'(1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < LAT_MAX) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("return_to_idle", CW'(busy), CW'(0));
    endtask

    initial begin
        int lat;
        int en1;
        logic [RW-1:0] res;
        rst_n = 1'b0;
        {start, abort, a_valid, b_valid} = '0;
        a_data = '0;
        b_data = '0;
        res_ready = 1'b1;
        {start1, abort1, a_valid1, b_valid1} = '0;
        a_data1 = '0;
        b_data1 = '0;
        res_ready1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", outs0(), CW'(0));
        check("reset_outputs_cols1", CW'({busy1, res_valid1, mac_clr1, done1, res_data1}), CW'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_job(1, 0, -1, 1'b0, lat, res);
        check("nominal_latency", CW'(lat), CW'(COLS + 3));
        check("nominal_lanes", CW'(res), CW'(all_lanes(72)));
        wait_idle();

        run_job(1, 1, -1, 1'b0, lat, res);
        check("stall_lanes", CW'(res), CW'(all_lanes(72)));
        wait_idle();

        rr_mode = 2;
        @(posedge clk);
        #1;
        run_job(0, 0, -1, 1'b0, lat, res);
        for (int i = 0; i < 5; i++) begin
            check("backpressure_valid", CW'(res_valid), CW'(1));
            check("backpressure_data", CW'(res_data), CW'(res));
            start = (i == 2);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        rr_mode = 0;
        wait_idle();
        repeat (2) begin
            @(posedge clk);
            #1;
            check("start_in_result_ignored", CW'(busy), CW'(0));
        end

        run_job(0, 0, 4, 1'b0, lat, res);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("after_abort_quiet", CW'({busy, res_valid}), CW'(0));
        end
        run_job(2, 0, -1, 1'b0, lat, res);
        check("ff_lanes", CW'(res), CW'(all_lanes(32'h07F008)));
        wait_idle();

        run_job(0, 0, 3, 1'b1, lat, res);
        @(posedge clk);
        #1;
        check("reset_no_resume", CW'(busy), CW'(0));
        run_job(0, 0, -1, 1'b0, lat, res);
        check("post_reset_latency", CW'(lat), CW'(COLS + 3));
        wait_idle();

        rr_mode = 1;
        for (int t = 0; t < 20; t++) begin
            run_job(0, 2, -1, 1'b0, lat, res);
            wait_idle();
        end
        rr_mode = 0;

        a_valid1 = 1'b1;
        b_valid1 = 1'b1;
        a_data1  = {8'd3, 8'd3};
        b_data1  = 8'd5;
        start1   = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        lat = 1;
        en1 = 0;
        while (!res_valid1 && lat < 50) begin
            @(negedge clk);
            if (mac_en1) en1++;
            @(posedge clk);
            #1;
            lat++;
        end
        check("cols1_latency", CW'(lat), CW'(4));
        check("cols1_beats", CW'(en1), CW'(1));
        check("cols1_lanes", CW'(res_data1), CW'({24'd15, 24'd15}));
        @(negedge clk);
        check("cols1_done", CW'(done1), CW'(1));
        a_valid1 = 1'b0;
        b_valid1 = 1'b0;
        @(posedge clk);
        #1;
        check("cols1_idle", CW'(busy1), CW'(0));

        check("scoreboard_drained", CW'(exp_q.size()), CW'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
